// File: rtl/core_reg_pkg.sv
// Shared helpers for the multi-port register file: address-width function and PC step.
package core_reg_pkg;

  localparam int PC_STEP  = 4;
  localparam int BUSY_MAX = 64;

  // Widest scoreboard vector any configuration is expected to carry.
  typedef logic [BUSY_MAX-1:0] busy_vec_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/core_reg_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback, set wins a same-cycle tie.
module core_reg_scoreboard
  import core_reg_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int NWR       = 1,
  parameter int NRD       = 2,
  parameter bit ZERO_REG0 = 1'b1,
  parameter bit BYPASS    = 1'b1,
  localparam int AW       = clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_addr,
  input  logic              re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy
);

  logic [NREG-1:0] busy_q, busy_nxt, set_only;
  logic            set_ok;

  assign set_ok = busy_set && !(ZERO_REG0 && (busy_addr == '0));

  always_comb begin
    busy_nxt = busy_q;
    set_only = busy_q;
    for (int p = 0; p < NWR; p++)
      if (we[p]) busy_nxt[waddr[p*AW +: AW]] = 1'b0;
    if (set_ok) begin
      busy_nxt[busy_addr] = 1'b1;
      set_only[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  // Without bypass a same-cycle clear is not yet visible, but a new issue is.
  for (genvar r = 0; r < NRD; r++) begin : g_rb
    always_ff @(posedge CLK) begin
      if (!RST_N)  rbusy[r] <= 1'b0;
      else if (re) rbusy[r] <= BYPASS ? busy_nxt[raddr[r*AW +: AW]]
                                      : set_only[raddr[r*AW +: AW]];
    end
  end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-port integer register file with registered reads, optional write bypass, PC and scoreboard.
module core_regfile_mp
  import core_reg_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NREG      = 32,
  parameter int          NRD       = 2,
  parameter int          NWR       = 1,
  parameter bit          ZERO_REG0 = 1'b1,
  parameter bit          BYPASS    = 1'b1,
  parameter [XLEN-1:0]   RESET_PC  = '0,
  localparam int         AW        = clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NWR-1:0]      WE,
  input  logic [NWR*AW-1:0]   WADDR,
  input  logic [NWR*XLEN-1:0] WDATA,
  input  logic                RE,
  input  logic [NRD*AW-1:0]   RADDR,
  output logic [NRD*XLEN-1:0] RDATA,
  output logic [NRD-1:0]      RBUSY,
  input  logic                BUSY_SET,
  input  logic [AW-1:0]       BUSY_ADDR,
  input  logic                PC_WE,
  input  logic                PC_INC,
  input  logic [XLEN-1:0]     PC_WDATA,
  output logic [XLEN-1:0]     PC
);

  logic [XLEN-1:0] regs [NREG];
  logic [NWR-1:0]  wr_ok;

  for (genvar p = 0; p < NWR; p++) begin : g_wok
    assign wr_ok[p] = WE[p] && !(ZERO_REG0 && (WADDR[p*AW +: AW] == '0));
  end

  // Later ports are applied last, so the highest-index port wins an address clash.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wr_ok[p]) regs[WADDR[p*AW +: AW]] <= WDATA[p*XLEN +: XLEN];
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [XLEN-1:0] rd_nxt;
    logic [AW-1:0]   ra;
    assign ra = RADDR[r*AW +: AW];

    always_comb begin
      rd_nxt = regs[ra];
      if (BYPASS)
        for (int p = 0; p < NWR; p++)
          if (wr_ok[p] && (WADDR[p*AW +: AW] == ra)) rd_nxt = WDATA[p*XLEN +: XLEN];
    end

    always_ff @(posedge CLK) begin
      if (!RST_N)  RDATA[r*XLEN +: XLEN] <= '0;
      else if (RE) RDATA[r*XLEN +: XLEN] <= rd_nxt;
    end
  end

  core_reg_scoreboard #(
    .NREG(NREG), .NWR(NWR), .NRD(NRD), .ZERO_REG0(ZERO_REG0), .BYPASS(BYPASS)
  ) u_sb (
    .CLK(CLK), .RST_N(RST_N), .we(WE), .waddr(WADDR),
    .busy_set(BUSY_SET), .busy_addr(BUSY_ADDR),
    .re(RE), .raddr(RADDR), .rbusy(RBUSY)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N)      PC <= RESET_PC;
    else if (PC_WE)  PC <= PC_WDATA;
    else if (PC_INC) PC <= PC + XLEN'(PC_STEP);
  end

endmodule

// File: tb/tb_core_regfile_mp.sv
// Directed bench for core_regfile_mp: two write ports, two read ports, bypass on, zeroed reg 0.
module tb_core_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [1:0]      WE;
  logic [2*AW-1:0] WADDR;
  logic [63:0]     WDATA;
  logic            RE;
  logic [2*AW-1:0] RADDR;
  logic [63:0]     RDATA;
  logic [1:0]      RBUSY;
  logic            BUSY_SET;
  logic [AW-1:0]   BUSY_ADDR;
  logic            PC_WE, PC_INC;
  logic [31:0]     PC_WDATA, PC;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  core_regfile_mp #(
    .XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG0(1'b1), .BYPASS(1'b1),
    .RESET_PC(32'h100)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(RDATA), .RBUSY(RBUSY),
    .BUSY_SET(BUSY_SET), .BUSY_ADDR(BUSY_ADDR),
    .PC_WE(PC_WE), .PC_INC(PC_INC), .PC_WDATA(PC_WDATA), .PC(PC)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    WE[p] = 1'b1;
    WADDR[p*AW +: AW] = a;
    WDATA[p*32 +: 32] = d;
  endtask

  task automatic idle();
    WE = '0; BUSY_SET = 1'b0; PC_WE = 1'b0; PC_INC = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; WE = '0; WADDR = '0; WDATA = '0; RE = 1'b1; RADDR = '0;
    BUSY_SET = 1'b0; BUSY_ADDR = '0; PC_WE = 1'b0; PC_INC = 1'b0; PC_WDATA = '0;

    // reset
    tick();
    chk("rst_pc", PC, 32'h100);
    chk("rst_rd0", RDATA[31:0], 32'h0);
    chk("rst_rd1", RDATA[63:32], 32'h0);
    chk("rst_rbusy", {30'b0, RBUSY}, 32'h0);
    RST_N = 1'b1;
    RADDR[0 +: AW] = 5'd5;
    tick();
    chk("rd_r5", RDATA[31:0], 32'h0);

    // plain write then read
    wr(0, 5'd3, 32'hDEADBEEF);
    tick();
    idle(); RADDR[0 +: AW] = 5'd3;
    tick();
    chk("rd_r3", RDATA[31:0], 32'hDEADBEEF);

    // reg 0 stays zero, including no bypass of the write
    wr(0, 5'd0, 32'h1234); RADDR[0 +: AW] = 5'd0;
    tick();
    chk("r0_bypass", RDATA[31:0], 32'h0);
    idle();
    tick();
    chk("r0_read", RDATA[31:0], 32'h0);

    // same-cycle bypass on read port 1
    wr(0, 5'd7, 32'hA5A5A5A5); RADDR[AW +: AW] = 5'd7;
    tick();
    chk("byp_r7", RDATA[63:32], 32'hA5A5A5A5);

    // both ports hit reg 9: port 1 wins
    idle(); wr(0, 5'd9, 32'h1); wr(1, 5'd9, 32'h2); RADDR[0 +: AW] = 5'd9;
    tick();
    chk("dual_byp", RDATA[31:0], 32'h2);
    idle();
    tick();
    chk("dual_rd", RDATA[31:0], 32'h2);
    chk("r7_hold", RDATA[63:32], 32'hA5A5A5A5);

    // scoreboard
    RADDR[0 +: AW] = 5'd4; RADDR[AW +: AW] = 5'd3;
    BUSY_SET = 1'b1; BUSY_ADDR = 5'd4;
    tick();
    chk("busy_set_same", {31'b0, RBUSY[0]}, 32'h1);
    chk("busy_other", {31'b0, RBUSY[1]}, 32'h0);
    idle();
    tick();
    chk("busy_held", {31'b0, RBUSY[0]}, 32'h1);
    wr(0, 5'd4, 32'h44); BUSY_SET = 1'b1; BUSY_ADDR = 5'd4;
    tick();
    chk("set_wins", {31'b0, RBUSY[0]}, 32'h1);
    chk("set_wins_data", RDATA[31:0], 32'h44);
    idle(); wr(0, 5'd4, 32'h55);
    tick();
    chk("clear_busy", {31'b0, RBUSY[0]}, 32'h0);
    chk("clear_data", RDATA[31:0], 32'h55);
    idle();

    // PC
    PC_WE = 1'b1; PC_WDATA = 32'hFFFFFFFC;
    tick();
    chk("pc_load", PC, 32'hFFFFFFFC);
    idle(); PC_INC = 1'b1;
    tick();
    chk("pc_wrap", PC, 32'h0);
    PC_WE = 1'b1; PC_INC = 1'b1; PC_WDATA = 32'h80;
    tick();
    chk("pc_we_prio", PC, 32'h80);
    idle();
    tick(); tick();
    chk("pc_hold", PC, 32'h80);
    PC_INC = 1'b1;
    tick();
    chk("pc_inc", PC, 32'h84);
    idle();

    // RE=0 freezes read outputs while writes and issue proceed
    RE = 1'b0; RADDR[0 +: AW] = 5'd10; RADDR[AW +: AW] = 5'd11;
    wr(0, 5'd10, 32'h111); BUSY_SET = 1'b1; BUSY_ADDR = 5'd11;
    tick();
    chk("freeze1", RDATA[31:0], 32'h55);
    idle(); wr(0, 5'd10, 32'h222);
    tick();
    chk("freeze2", RDATA[31:0], 32'h55);
    wr(0, 5'd10, 32'h333);
    tick();
    chk("freeze3", RDATA[31:0], 32'h55);
    chk("freeze_busy", {31'b0, RBUSY[1]}, 32'h0);
    idle(); RE = 1'b1;
    tick();
    chk("unfreeze", RDATA[31:0], 32'h333);
    chk("unfreeze_busy", {31'b0, RBUSY[1]}, 32'h1);

    // mid-stream reset wins over everything else
    RST_N = 1'b0; wr(0, 5'd10, 32'h999); PC_INC = 1'b1; BUSY_SET = 1'b1; BUSY_ADDR = 5'd10;
    tick();
    chk("rst2_pc", PC, 32'h100);
    chk("rst2_rd0", RDATA[31:0], 32'h0);
    chk("rst2_rd1", RDATA[63:32], 32'h0);
    chk("rst2_rbusy", {30'b0, RBUSY}, 32'h0);
    RST_N = 1'b1; idle();
    tick();
    chk("rst2_r10", RDATA[31:0], 32'h0);
    chk("rst2_busy11", {31'b0, RBUSY[1]}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
